// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a
// single-port synchronous RAM with one cycle of read latency.
// Ports can lock RAM ownership across several accesses.
// Optional feature: define MEM_ARB_RR_EN to replace the fixed port-1 tie-break
// with a round-robin tie-break.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic                  p0_lock,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic                  p1_lock,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_write,
    output logic                  ram_read,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [DATA_WIDTH-1:0] wdata_hold;
    logic [DATA_WIDTH-1:0] p0_rdata_hold;
    logic [DATA_WIDTH-1:0] p1_rdata_hold;

`ifdef MEM_ARB_RR_EN
    // 1 = port 1 was granted most recently, so port 0 wins the next tie
    logic last_gnt;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant selection and next-state logic; grants are forced low during reset
    always_comb begin
        p0_gnt     = 1'b0;
        p1_gnt     = 1'b0;
        state_next = state;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (p0_req && p1_req) begin
`ifdef MEM_ARB_RR_EN
                        if (last_gnt) begin
                            p0_gnt = 1'b1;
                        end else begin
                            p1_gnt = 1'b1;
                        end
`else
                        p1_gnt = 1'b1;
`endif
                    end else if (p0_req) begin
                        p0_gnt = 1'b1;
                    end else if (p1_req) begin
                        p1_gnt = 1'b1;
                    end
                    if (p0_gnt && p0_lock) begin
                        state_next = OWN0;
                    end else if (p1_gnt && p1_lock) begin
                        state_next = OWN1;
                    end
                end
                OWN0: begin
                    p0_gnt = p0_req;
                    if (p0_req && !p0_lock) begin
                        state_next = IDLE;
                    end
                end
                OWN1: begin
                    p1_gnt = p1_req;
                    if (p1_req && !p1_lock) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // RAM command comes straight from the granted port; address/data hold otherwise
    always_comb begin
        ram_write   = 1'b0;
        ram_read    = 1'b0;
        ram_address = addr_hold;
        ram_data_in = wdata_hold;
        if (p0_gnt) begin
            ram_write   = p0_we;
            ram_read    = ~p0_we;
            ram_address = p0_addr;
            ram_data_in = p0_wdata;
        end else if (p1_gnt) begin
            ram_write   = p1_we;
            ram_read    = ~p1_we;
            ram_address = p1_addr;
            ram_data_in = p1_wdata;
        end
    end

    // Remember the last driven RAM address/data so the bus holds between grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else if (p0_gnt || p1_gnt) begin
            addr_hold  <= ram_address;
            wdata_hold <= ram_data_in;
        end
    end

    // Read-valid pulses one cycle after a read grant; reset cancels a pending one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end else begin
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
        end
    end

    // Capture returned read data so rdata holds while rvalid is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rdata_hold <= '0;
            p1_rdata_hold <= '0;
        end else begin
            if (p0_rvalid) begin
                p0_rdata_hold <= ram_data_out;
            end
            if (p1_rvalid) begin
                p1_rdata_hold <= ram_data_out;
            end
        end
    end

    assign p0_rdata = p0_rvalid ? ram_data_out : p0_rdata_hold;
    assign p1_rdata = p1_rvalid ? ram_data_out : p1_rdata_hold;

`ifdef MEM_ARB_RR_EN
    // Track which port was granted last, including grants made while locked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (p0_gnt) begin
            last_gnt <= 1'b0;
        end else if (p1_gnt) begin
            last_gnt <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter with a read-data
// scoreboard. Expected read responses are queued when a read grant is expected
// and a negedge monitor checks every rvalid against the queue.
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req = 1'b0, p0_we = 1'b0, p0_lock = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p0_gnt, p0_rvalid;
    logic [DW-1:0] p0_rdata;
    logic          p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p1_gnt, p1_rvalid;
    logic [DW-1:0] p1_rdata;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic          ram_write, ram_read;
    logic [DW-1:0] ram_data_out = '0;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write(ram_write), .ram_read(ram_read), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            cycle;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [DW-1:0] mem [0:255];

    // Cycle counter used to time-stamp expected read responses
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous RAM with one cycle of read latency
    always @(posedge clk) begin
        if (ram_write) mem[ram_address[7:0]] <= ram_data_in;
        if (ram_read) ram_data_out <= mem[ram_address[7:0]];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every cycle, rvalid must match the queue head exactly
    logic mon_e0, mon_e1;
    always @(negedge clk) begin
        while (q0.size() > 0 && q0[0].cycle < cyc) begin
            tests++; fails++;
            $display("[TB] FAIL p0_rvalid_missed: expected data %0h at cycle %0d", q0[0].data, q0[0].cycle);
            void'(q0.pop_front());
        end
        while (q1.size() > 0 && q1[0].cycle < cyc) begin
            tests++; fails++;
            $display("[TB] FAIL p1_rvalid_missed: expected data %0h at cycle %0d", q1[0].data, q1[0].cycle);
            void'(q1.pop_front());
        end
        mon_e0 = (q0.size() > 0) && (q0[0].cycle == cyc);
        mon_e1 = (q1.size() > 0) && (q1[0].cycle == cyc);
        check("p0_rvalid", {127'd0, p0_rvalid}, {127'd0, mon_e0});
        check("p1_rvalid", {127'd0, p1_rvalid}, {127'd0, mon_e1});
        if (mon_e0) begin
            if (p0_rvalid) check("p0_rdata", {96'd0, p0_rdata}, {96'd0, q0[0].data});
            void'(q0.pop_front());
        end
        if (mon_e1) begin
            if (p1_rvalid) check("p1_rdata", {96'd0, p1_rdata}, {96'd0, q1[0].data});
            void'(q1.pop_front());
        end
    end

    task automatic applyStimulus(
        input logic r0, input logic w0, input logic l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
        input logic r1, input logic w1, input logic l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        p0_req = r0; p0_we = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
    endtask

    // Check one cycle's grants and RAM command, queue expected read data, advance
    task automatic checkOutput(input string name, input logic eg0, input logic eg1,
                               input logic [DW-1:0] ed0, input logic [DW-1:0] ed1);
        exp_t e;
        @(negedge clk);
        check({name, "_gnt"}, {126'd0, p0_gnt, p1_gnt}, {126'd0, eg0, eg1});
        if (eg0) begin
            check({name, "_ram_cmd"}, {94'd0, ram_address, ram_write, ram_read, ram_data_in},
                  {94'd0, p0_addr, p0_we, ~p0_we, p0_wdata});
            if (!p0_we) begin e.data = ed0; e.cycle = cyc + 1; q0.push_back(e); end
        end else if (eg1) begin
            check({name, "_ram_cmd"}, {94'd0, ram_address, ram_write, ram_read, ram_data_in},
                  {94'd0, p1_addr, p1_we, ~p1_we, p1_wdata});
            if (!p1_we) begin e.data = ed1; e.cycle = cyc + 1; q1.push_back(e); end
        end else begin
            check({name, "_ram_idle"}, {126'd0, ram_write, ram_read}, 128'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string name);
        check({name, "_ctl"}, {122'd0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_write, ram_read}, 128'd0);
        check({name, "_data"}, {16'd0, p0_rdata, p1_rdata, ram_address, ram_data_in}, 128'd0);
    endtask

    initial begin
        logic eg0;
        logic [DW-1:0] exp_data [0:3];
        exp_data[0] = 32'hA; exp_data[1] = 32'hB; exp_data[2] = 32'hC; exp_data[3] = 32'hD;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[1] = 32'hA; mem[2] = 32'hB; mem[3] = 32'hC; mem[4] = 32'hD;
        mem[8'h20] = 32'h1234_5678;

        @(negedge clk);
        checkReset("reset_init");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // p1 write then p0 read of the same address
        applyStimulus(0, 0, 0, 16'h0, 32'h0, 1, 1, 0, 16'h0010, 32'hDEADBEEF);
        checkOutput("wr_p1", 0, 1, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 16'h0010, 32'h0, 0, 0, 0, 16'h0, 32'h0);
        checkOutput("rd_p0", 1, 0, 32'hDEADBEEF, 32'h0);

        // p1 locks ownership; p0 keeps requesting and is blocked until unlock
        applyStimulus(1, 0, 0, 16'h0030, 32'h0, 1, 0, 1, 16'h0020, 32'h0);
        checkOutput("lock_rd_p1", 0, 1, 32'h0, 32'h1234_5678);
        applyStimulus(1, 0, 0, 16'h0030, 32'h0, 0, 0, 0, 16'h0, 32'h0);
        checkOutput("lock_hold", 0, 0, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 16'h0030, 32'h0, 1, 1, 0, 16'h0020, 32'hCAFEF00D);
        checkOutput("unlock_wr_p1", 0, 1, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 16'h0030, 32'h0, 0, 0, 0, 16'h0, 32'h0);
        checkOutput("p0_after_unlock", 1, 0, 32'h1000_0030, 32'h0);

        // Both ports read for 4 cycles: fixed priority favours p1, RR alternates
        applyStimulus(1, 0, 0, 16'h0001, 32'h0, 1, 0, 0, 16'h0002, 32'h0);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            eg0 = (i % 2 == 1);
`else
            eg0 = 1'b0;
`endif
            checkOutput("tie", eg0, ~eg0, 32'hA, 32'hB);
        end

        // Back-to-back p0 reads
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, AW'(i + 1), 32'h0, 0, 0, 0, 16'h0, 32'h0);
            checkOutput("b2b_rd", 1, 0, exp_data[i], 32'h0);
        end

        // Idle cycles: no commands, bus and read data hold
        applyStimulus(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0);
        for (int i = 0; i < 3; i++) checkOutput("idle", 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        check("addr_hold", {112'd0, ram_address}, {112'd0, 16'h0004});
        check("rdata_hold", {96'd0, p0_rdata}, {96'd0, 32'hD});
        @(posedge clk); #1;

        // Locked p0 read, then reset before its rvalid can be seen
        applyStimulus(1, 0, 1, 16'h0003, 32'h0, 0, 0, 0, 16'h0, 32'h0);
        checkOutput("rd_before_rst", 1, 0, 32'hC, 32'h0);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        applyStimulus(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0);
        @(negedge clk);
        checkReset("reset_mid");
        @(posedge clk); #1;
        applyStimulus(1, 0, 0, 16'h0004, 32'h0, 1, 0, 0, 16'h0002, 32'h0);
        @(negedge clk);
        checkReset("reset_req");
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 16'h0, 32'h0, 1, 0, 0, 16'h0002, 32'h0);
        checkOutput("post_rst_p1", 0, 1, 32'h0, 32'hB);
        applyStimulus(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0);
        checkOutput("drain", 0, 0, 32'h0, 32'h0);
        checkOutput("drain", 0, 0, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
